saradc_scan: RTL and testbench

//  Parametrised SAR ADC sequencer; next generation of the single-channel 5-bit controller.

---
 rtl/saradc_scan.sv | 244 ++++++++++++++++++++++++
 tb/tb_saradc_scan.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/saradc_scan.sv
// -----------------------------------------------------------------------------
// saradc_scan
// Successive-approximation ADC sequencer with a multi-channel analog-mux scan.
// It drives the sample/hold, the DAC code and the mux select of an external
// analog front end, reads back the comparator and produces tagged results.
//
// Ports
//   clock_i        single clock, all state changes on the rising edge
//   reset_i        asynchronous active-high reset
//   nStartCnv_i    active-low start request, level-sampled while idle
//   cont_mode_i    1 = rescan continuously, 0 = one scan then stop
//   ch_mask_i      channel enable mask, latched when a scan starts
//   CompOut_i      comparator, 1 = DAC(B) above the held input
//   SH_o           sample/hold control, 1 = track
//   nEndCnv_o      0 = idle/finished, 1 = scan in progress
//   B_o            DAC code (SAR register)
//   ch_sel_o       analog mux select
//   dataOut_o      last converted result
//   data_ch_o      channel of dataOut_o
//   data_valid_o   one-cycle strobe when dataOut_o/data_ch_o update
//
// Every output is a register. Each state's listed output values are loaded on
// the edge that enters that state, so they are visible for the whole state.
// The result registers are loaded on the edge that leaves STORE, which puts
// the strobe SAMPLE_CYC + 1 + NBITS*(2+SETTLE) + 1 cycles after SAMPLE entry.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module saradc_scan #(
  parameter int NBITS      = 8,
  parameter int NCH        = 4,
  parameter int CHW        = 2,
  parameter int SAMPLE_CYC = 2,
  parameter int SETTLE     = 1
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             nStartCnv_i,
  input  logic             cont_mode_i,
  input  logic [NCH-1:0]   ch_mask_i,
  input  logic             CompOut_i,
  output logic             SH_o,
  output logic             nEndCnv_o,
  output logic [NBITS-1:0] B_o,
  output logic [CHW-1:0]   ch_sel_o,
  output logic [NBITS-1:0] dataOut_o,
  output logic [CHW-1:0]   data_ch_o,
  output logic             data_valid_o
);

  localparam int KW   = $clog2(NBITS);
  localparam int CNTW = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_HOLD,
    S_SET,
    S_SETTLE,
    S_CHECK,
    S_STORE,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [NCH-1:0]   mask_q, mask_d;
  logic [KW-1:0]    k_q, k_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             sh_q, sh_d;
  logic             nend_q, nend_d;
  logic [NBITS-1:0] b_q, b_d;
  logic [CHW-1:0]   ch_sel_q, ch_sel_d;
  logic [NBITS-1:0] dout_q, dout_d;
  logic [CHW-1:0]   dch_q, dch_d;
  logic             dv_q, dv_d;

  // Index of the lowest set bit; zero when nothing is set (callers guard that).
  function automatic logic [CHW-1:0] lowest_set(input logic [NCH-1:0] v);
    logic [CHW-1:0] idx;
    idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (v[i]) idx = CHW'(i);
    end
    return idx;
  endfunction

  // Enabled channels strictly above the current selection, from the latched
  // mask; the lowest of these is the next channel of the running scan.
  logic [NCH-1:0] above_ch;
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_above
      assign above_ch[gi] = mask_q[gi] && (gi > int'(ch_sel_q));
    end
  endgenerate

  logic           has_next;
  logic [CHW-1:0] next_ch;
  logic [CHW-1:0] first_ch;
  logic [CHW-1:0] restart_ch;

  assign has_next   = |above_ch;
  assign next_ch    = lowest_set(above_ch);
  assign first_ch   = lowest_set(ch_mask_i);
  assign restart_ch = lowest_set(mask_q);

  // State and output registers
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      mask_q   <= '0;
      k_q      <= '0;
      cnt_q    <= '0;
      sh_q     <= 1'b0;
      nend_q   <= 1'b0;
      b_q      <= '0;
      ch_sel_q <= '0;
      dout_q   <= '0;
      dch_q    <= '0;
      dv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      nend_q   <= nend_d;
      b_q      <= b_d;
      ch_sel_q <= ch_sel_d;
      dout_q   <= dout_d;
      dch_q    <= dch_d;
      dv_q     <= dv_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    nend_d   = nend_q;
    b_d      = b_q;
    ch_sel_d = ch_sel_q;
    dout_d   = dout_q;
    dch_d    = dch_q;
    dv_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // A start with an empty mask is simply ignored.
        if (!nStartCnv_i && (ch_mask_i != '0)) begin
          mask_d   = ch_mask_i;
          ch_sel_d = first_ch;
          nend_d   = 1'b1;
          sh_d     = 1'b1;
          b_d      = '1;
          cnt_d    = '0;
          state_d  = S_SAMPLE;
        end
      end

      S_SAMPLE: begin
        if (cnt_q == CNTW'(SAMPLE_CYC - 1)) begin
          sh_d    = 1'b0;
          b_d     = '0;
          k_d     = KW'(NBITS - 1);
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end

      S_HOLD: begin
        b_d[k_q] = 1'b1;
        state_d  = S_SET;
      end

      S_SET: begin
        if (SETTLE > 0) begin
          cnt_d   = '0;
          state_d = S_SETTLE;
        end else begin
          state_d = S_CHECK;
        end
      end

      S_SETTLE: begin
        if (cnt_q == CNTW'(SETTLE - 1)) begin
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end

      S_CHECK: begin
        // Drop the trial bit if the DAC overshot, then either place the next
        // trial bit (entering SET) or finish with the bit-0 decision applied.
        if (CompOut_i) b_d[k_q] = 1'b0;
        if (k_q != '0) begin
          b_d[k_q - KW'(1)] = 1'b1;
          k_d               = k_q - KW'(1);
          state_d           = S_SET;
        end else begin
          state_d = S_STORE;
        end
      end

      S_STORE: begin
        dout_d = b_q;
        dch_d  = ch_sel_q;
        dv_d   = 1'b1;
        if (has_next || cont_mode_i) begin
          // Wrap-around reuses the mask latched at scan start.
          ch_sel_d = has_next ? next_ch : restart_ch;
          sh_d     = 1'b1;
          b_d      = '1;
          cnt_d    = '0;
          state_d  = S_SAMPLE;
        end else begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        nend_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign SH_o         = sh_q;
  assign nEndCnv_o    = nend_q;
  assign B_o          = b_q;
  assign ch_sel_o     = ch_sel_q;
  assign dataOut_o    = dout_q;
  assign data_ch_o    = dch_q;
  assign data_valid_o = dv_q;

endmodule

// File: tb/tb_saradc_scan.sv
// -----------------------------------------------------------------------------
// tb_saradc_scan
// Bench for saradc_scan. A transaction-level model (per-channel latency
// countdown plus scan order derived from the mask) predicts nEndCnv, SH,
// ch_sel, data_valid, dataOut and data_ch; one compare process checks them on
// every cycle. Directed scenarios pin the model with literal expectations, a
// randomized phase exercises masks, starts, continuous mode and stray inputs,
// and a second instance (NBITS=10, SETTLE=3) checks the longer timing.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_saradc_scan;

  localparam int NB   = 8;
  localparam int SCYC = 2;
  localparam int STL  = 1;
  localparam int LAT  = SCYC + 1 + NB * (2 + STL) + 1;   // 28

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic nstart = 1'b1;
  logic cont = 1'b0;
  logic [3:0] mask = 4'b0000;
  logic sh, nend, dv, comp;
  logic [7:0] b, dout;
  logic [1:0] chsel, dch;
  logic [7:0] vin [4];

  // Second instance: 10-bit resolution, 3-cycle settle
  logic nstart6 = 1'b1;
  logic cont6 = 1'b0;
  logic [3:0] mask6 = 4'b0001;
  logic sh6, nend6, dv6, comp6;
  logic [9:0] b6, dout6;
  logic [1:0] chsel6, dch6;
  logic [9:0] vin6 [4];

  // Ideal comparator on the selected held input
  assign comp  = (b > vin[chsel]);
  assign comp6 = (b6 > vin6[chsel6]);

  always #5 clk = ~clk;

  saradc_scan dut (
    .clock_i(clk), .reset_i(rst), .nStartCnv_i(nstart), .cont_mode_i(cont),
    .ch_mask_i(mask), .CompOut_i(comp), .SH_o(sh), .nEndCnv_o(nend), .B_o(b),
    .ch_sel_o(chsel), .dataOut_o(dout), .data_ch_o(dch), .data_valid_o(dv)
  );

  saradc_scan #(.NBITS(10), .NCH(4), .CHW(2), .SAMPLE_CYC(2), .SETTLE(3)) dut6 (
    .clock_i(clk), .reset_i(rst), .nStartCnv_i(nstart6), .cont_mode_i(cont6),
    .ch_mask_i(mask6), .CompOut_i(comp6), .SH_o(sh6), .nEndCnv_o(nend6), .B_o(b6),
    .ch_sel_o(chsel6), .dataOut_o(dout6), .data_ch_o(dch6), .data_valid_o(dv6)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // ---------------- behavioural model ----------------
  bit       m_busy = 1'b0;
  bit       m_done = 1'b0;
  int       m_phase = 0;     // cycles since the current channel's SAMPLE entry
  logic [3:0] m_mask = 4'b0000;
  int       m_cur = 0;
  bit       e_dv = 1'b0;
  logic [7:0] e_data = 8'h00;
  int       e_ch = 0;

  // Lowest enabled channel strictly above 'above'; -1 if none.
  function automatic int lowest_from(input logic [3:0] m, input int above);
    for (int i = 0; i < 4; i++) if (m[i] && i > above) return i;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    int nxt;
    if (rst) begin
      m_busy = 0; m_done = 0; m_phase = 0; m_cur = 0;
      e_dv = 0; e_data = 8'h00; e_ch = 0;
    end else begin
      e_dv = 0;
      if (!m_busy) begin
        if (!nstart && mask != 4'b0000) begin
          m_busy = 1; m_mask = mask; m_cur = lowest_from(mask, -1); m_phase = 0;
        end
      end else if (m_done) begin
        m_busy = 0; m_done = 0;
      end else if (m_phase == LAT - 1) begin
        // SAR with an ideal comparator reproduces the held input exactly
        e_dv = 1; e_data = vin[m_cur]; e_ch = m_cur;
        nxt = lowest_from(m_mask, m_cur);
        if (nxt >= 0) begin
          m_cur = nxt; m_phase = 0;
        end else if (cont) begin
          m_cur = lowest_from(m_mask, -1); m_phase = 0;
        end else begin
          m_done = 1;
        end
      end else begin
        m_phase++;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (checking) begin
      check("nEndCnv", nend, m_busy);
      check("data_valid", dv, e_dv);
      check("dataOut", dout, e_data);
      check("data_ch", dch, e_ch);
      if (m_busy && !m_done) begin
        check("ch_sel", chsel, m_cur);
        check("SH", sh, (m_phase < SCYC));
      end else if (!m_busy) begin
        check("SH_idle", sh, 0);
      end
    end
  end

  // ---------------- transaction log ----------------
  int s_cyc[$];
  int s_ch[$];
  int s_dat[$];
  int st_cyc = 0;
  int end_cyc = 0;
  logic [3:0] seen = 4'b0000;
  logic prev_nend = 1'b0;

  always @(negedge clk) begin
    if (nend === 1'b1 && prev_nend !== 1'b1) st_cyc = cyc;
    if (nend === 1'b0 && prev_nend === 1'b1) end_cyc = cyc;
    if (nend === 1'b1) seen[chsel] = 1'b1;
    if (dv === 1'b1) begin
      s_cyc.push_back(cyc); s_ch.push_back(int'(dch)); s_dat.push_back(int'(dout));
      $display("[TB] result cyc=%0d ch=%0d data=%02h", cyc, dch, dout);
    end
    prev_nend = nend;
  end

  task automatic clear_log();
    s_cyc.delete(); s_ch.delete(); s_dat.delete(); seen = 4'b0000;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic start_pulse();
    nstart = 1'b0; cycles(1); nstart = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((nend !== 1'b0 || m_busy) && n < budget) begin cycles(1); n++; end
    check("wait_idle_timeout", nend, 0);
  endtask

  function automatic int at_or(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [9:0] bh [60];
  int dv6_at;

  initial begin
    for (int c = 0; c < 4; c++) begin vin[c] = 8'h00; vin6[c] = 10'h000; end
    cycles(3);
    // reset state
    check("rst_SH", sh, 0); check("rst_nEndCnv", nend, 0); check("rst_B", b, 0);
    check("rst_ch_sel", chsel, 0); check("rst_dataOut", dout, 0);
    check("rst_data_ch", dch, 0); check("rst_data_valid", dv, 0);
    rst = 1'b0;
    checking = 1'b1;
    cycles(2);

    // 1) single channel, single scan
    clear_log();
    vin[0] = 8'hA5; mask = 4'b0001;
    start_pulse();
    wait_idle(200);
    check("s1_count", s_cyc.size(), 1);
    check("s1_data", at_or(s_dat, 0), 32'hA5);
    check("s1_ch", at_or(s_ch, 0), 0);
    check("s1_latency", at_or(s_cyc, 0) - st_cyc, 28);
    check("s1_nend_fall", end_cyc - at_or(s_cyc, 0), 1);

    // 2) mask 1010
    clear_log();
    vin[1] = 8'h00; vin[3] = 8'hFF; mask = 4'b1010;
    start_pulse();
    wait_idle(300);
    check("s2_count", s_cyc.size(), 2);
    check("s2_ch0", at_or(s_ch, 0), 1); check("s2_d0", at_or(s_dat, 0), 32'h00);
    check("s2_ch1", at_or(s_ch, 1), 3); check("s2_d1", at_or(s_dat, 1), 32'hFF);
    check("s2_spacing", at_or(s_cyc, 1) - at_or(s_cyc, 0), 28);
    check("s2_first", at_or(s_cyc, 0) - st_cyc, 28);
    check("s2_ch0_never", seen[0], 0);
    check("s2_ch2_never", seen[2], 0);

    // 3) continuous, mask 0101; drop cont during the second ch0 conversion
    clear_log();
    vin[0] = 8'h3C; vin[2] = 8'hC3; mask = 4'b0101; cont = 1'b1;
    start_pulse();
    cycles(2 * LAT + 5);
    cont = 1'b0;
    wait_idle(300);
    check("s3_count", s_cyc.size(), 4);
    for (int i = 0; i < 4; i++) check("s3_ch_order", at_or(s_ch, i), (i % 2) * 2);
    check("s3_last_data", at_or(s_dat, 3), 32'hC3);

    // 4) empty mask ignored; start during conversion ignored
    clear_log();
    mask = 4'b0000; nstart = 1'b0;
    cycles(10);
    check("s4_nend", nend, 0);
    check("s4_strobes", s_cyc.size(), 0);
    nstart = 1'b1; mask = 4'b0001; vin[0] = 8'h71;
    start_pulse();
    cycles(5);
    mask = 4'b1111; start_pulse(); mask = 4'b0110;
    wait_idle(300);
    check("s4_count", s_cyc.size(), 1);
    check("s4_data", at_or(s_dat, 0), 32'h71);

    // 5) reset during SETTLE of bit 4
    clear_log();
    vin[0] = 8'($urandom_range(0, 255)); mask = 4'b0001;
    start_pulse();
    begin
      int n;
      n = 0;
      while (!(m_busy && m_phase == 13) && n < 100) begin cycles(1); n++; end
      check("s5_reach_settle", n < 100, 1);
    end
    check("s5_B_before", b, (vin[0] & 8'hE0) | 8'h10);
    rst = 1'b1;
    #1;
    check("s5_SH", sh, 0); check("s5_nEndCnv", nend, 0); check("s5_B", b, 0);
    check("s5_ch_sel", chsel, 0); check("s5_dataOut", dout, 0);
    check("s5_data_ch", dch, 0); check("s5_data_valid", dv, 0);
    cycles(2);
    rst = 1'b0;
    cycles(2);
    check("s5_no_strobe", s_cyc.size(), 0);
    vin[0] = 8'h5A;
    start_pulse();
    wait_idle(200);
    check("s5_after_data", at_or(s_dat, 0), 32'h5A);

    // randomized phase
    for (int it = 0; it < 16; it++) begin
      for (int c = 0; c < 4; c++) vin[c] = 8'($urandom_range(0, 255));
      mask = 4'($urandom_range(0, 15));
      cont = ($urandom_range(0, 3) == 0);
      nstart = 1'b0; cycles($urandom_range(1, 3)); nstart = 1'b1;
      for (int c = 0; c < 60; c++) begin
        if ($urandom_range(0, 9) == 0) nstart = ~nstart;
        mask = 4'($urandom_range(0, 15));
        cycles(1);
      end
      nstart = 1'b1; cont = 1'b0;
      cycles(1);
      wait_idle(400);
    end

    // 6) NBITS=10, SETTLE=3 instance
    vin6[0] = 10'h2AA;
    dv6_at = -1;
    nstart6 = 1'b0; cycles(1); nstart6 = 1'b1;   // now in SAMPLE entry cycle (0)
    for (int i = 0; i < 60; i++) begin
      bh[i] = b6;
      if (dv6 === 1'b1 && dv6_at < 0) dv6_at = i;
      cycles(1);
    end
    check("s6_B_sample", bh[0], 10'h3FF);
    check("s6_B_hold", bh[2], 10'h000);
    check("s6_B_first_trial", bh[3], 10'h200);
    for (int j = 0; j < 10; j++) begin
      int w;
      w = 3 + 5 * j;
      check("s6_B_settle_stable", (bh[w+1] == bh[w]) && (bh[w+2] == bh[w]) && (bh[w+3] == bh[w]), 1);
    end
    check("s6_latency", dv6_at, 54);
    check("s6_data", dout6, 10'h2AA);
    check("s6_nend", nend6, 0);

    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
